serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial full adder: adds two WIDTH-bit unsigned operands plus a carry-in, one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop.
- It is the addition counterpart to the team's gate-level full subtractor, and is intended for area-constrained datapaths where multi-cycle latency is acceptable.
- Operands load on a start pulse; the result is presented with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle completion pulse.
- sum  output  WIDTH  result; held stable between completions.
- cout  output  1  final carry-out; held stable with sum.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flip-flop and bit counter are cleared.
- State machine: IDLE, RUN, DONE. The encoding is free.
- IDLE:
  - On an edge E0 with start=1: load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, and go to RUN.
  - Otherwise remain in IDLE.
- RUN (busy=1), on each edge:
  - s = a_sh[0]^b_sh[0]^carry.
  - carry <= (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0])).
  - Shift a_sh and b_sh right by 1.
  - Shift s into the MSB of the internal result register r (r shifts right).
  - cnt <= cnt+1.
- RUN completion:
  - The edge that processes bit WIDTH-1 (edge E_WIDTH) also does sum<=final r, cout<=final carry, done<=1, state<=DONE.
  - sum must equal the completed r including the bit computed on that edge. Use the next-value of r, not the registered value.
- DONE: done=1 and busy=0 for exactly one cycle; the next edge returns to IDLE with done<=0.
- Latency:
  - Start is accepted at E0.
  - busy is high for cycles E0..E_WIDTH, i.e. exactly WIDTH cycles.
  - done is high in the cycle following E_WIDTH.
  - Accepted start to done is WIDTH+1 edges.
- Arithmetic: {cout,sum} == a+b+cin, computed modulo 2^(WIDTH+1). No signed interpretation.
- sum and cout change only at the completion edge or on reset. They keep the previous result during RUN.
- start while busy or in DONE: ignored, with no effect on the operation in flight. A start held high in DONE is accepted in the following IDLE cycle (a new op every WIDTH+2 cycles maximum).
- a, b and cin are don't-care except at the accepted start edge. Changes during RUN have no effect.
- Reset asserted mid-RUN: the operation is aborted immediately and all outputs return to reset values. No done pulse is issued.
- cnt is wide enough to hold WIDTH-1, i.e. $clog2(WIDTH) bits, minimum 1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output ovf (1 bit).
  - ovf = signed two's-complement overflow, i.e. the carry into the MSB XOR the carry out of the MSB, captured at the completion edge alongside sum.
  - ovf is held with sum and reset to 0.
- Undefined: no ovf port and no associated logic. All other behaviour is identical.

Test Plan (WIDTH=8):
- Reset, then a=0x00, b=0x00, cin=0 with start=1 for one cycle -> busy high for 8 cycles; done pulse on cycle 9 after start; sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with SERIAL_ADDER_OVF_EN, ovf=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
- Start a=0xA5, b=0x5A, cin=1; during RUN, pulse start with a=0x11, b=0x22 -> second start ignored; result sum=0x00, cout=1; exactly one done pulse.
- Start an op, drop rst_n at cycle 4 of RUN -> busy=0, done=0, sum=0, cout=0 immediately. Release reset, start a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0.
- Hold start=1 continuously with a=0x03, b=0x04, cin=0 -> done pulses every 10 cycles; sum=0x07 stable between pulses; start ignored while done=1.

Source files
------------

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one full-adder cell and a carry flop, LSB first; optional ovf output under SERIAL_ADDER_OVF_EN
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CNT_W = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_s;
    logic               w_c;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    // Single full-adder cell working on the current LSBs and the carry flop
    always_comb begin
        w_s        = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
        w_c        = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
        w_res_next = {w_s, r_res[WIDTH-1:1]};
        w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and status outputs; start is only looked at in IDLE
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting, and result latch on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_c;
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // The last bit is folded in via the next-value, not the registered r_res
                    if (w_last) begin
                        r_sum  <= w_res_next;
                        r_cout <= w_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the last bit r_carry is the carry into the MSB and w_c the carry out of it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_RUN && w_last) begin
            r_ovf <= r_carry ^ w_c;
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (vector table, corner sequences, random ops vs. arithmetic model)
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vc;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed readings of the operands
    function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return t[W:0];
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int sx, sy, t;
        sx = (int'(x) >= 2**(W-1)) ? int'(x) - 2**W : int'(x);
        sy = (int'(y) >= 2**(W-1)) ? int'(y) - 2**W : int'(y);
        t  = sx + sy + int'(c);
        return (t > 2**(W-1) - 1) || (t < -(2**(W-1)));
    endfunction

    // One complete operation: checks latency, busy length, held result during RUN, result, single done
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input bit mid_start, input bit scramble, input string name);
        logic [W-1:0] prev_sum;
        logic         prev_cout;
        int           n;
        int           busy_cnt;
        int           extra;
        @(negedge clk);
        prev_sum  = sum;
        prev_cout = cout;
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            check({name, " held_sum"}, {63'd0, sum == prev_sum && cout == prev_cout}, 64'd1);
            if (scramble) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            if (mid_start) begin
                if (n == 3) begin
                    start = 1'b1; a = 8'h11; b = 8'h22;
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({name, " latency"}, n, W);
        check({name, " busy_cycles"}, busy_cnt, W);
        check({name, " busy_in_done"}, {63'd0, busy}, 64'd0);
        check({name, " sum"}, {56'd0, sum}, {56'd0, es});
        check({name, " cout"}, {63'd0, cout}, {63'd0, ec});
`ifdef SERIAL_ADDER_OVF_EN
        check({name, " ovf"}, {63'd0, ovf}, {63'd0, eo});
`else
        if (eo === 1'bx) $display("note: ovf unused");
`endif
        extra = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check({name, " single_done"}, extra, 0);
    endtask

    initial begin
        logic [W:0] m;
        logic [W-1:0] ra, rb;
        logic rc;
        int t_prev, pulses, cyc;

        tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[4] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[7] = '{8'h55, 8'h2A, 1'b1, 8'h80, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset sum",  {56'd0, sum},  64'd0);
        check("reset cout", {63'd0, cout}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(tbl[i].va, tbl[i].vb, tbl[i].vc, tbl[i].es, tbl[i].ec, tbl[i].eo,
                   1'b0, 1'b0, $sformatf("vec%0d", i));

        // Start pulsed mid-RUN with other operands must be ignored
        run_op(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, "mid_start");

        // Reset in the middle of RUN aborts and clears outputs immediately
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, "pre_abort");
        @(negedge clk);
        a = 8'h33; b = 8'h44; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {63'd0, busy}, 64'd0);
        check("abort done", {63'd0, done}, 64'd0);
        check("abort sum",  {56'd0, sum},  64'd0);
        check("abort cout", {63'd0, cout}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("abort no_done", pulses, 0);
        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, "post_abort");

        // Start held high: one operation every W+2 cycles, result stable between pulses
        @(negedge clk);
        a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
        t_prev = -1; pulses = 0; cyc = 0;
        repeat (4 * (W + 2)) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                pulses++;
                check("hold sum", {56'd0, sum}, 64'h07);
                if (t_prev >= 0) check("hold period", cyc - t_prev, W + 2);
                t_prev = cyc;
            end else if (pulses > 0) begin
                check("hold stable", {56'd0, sum}, 64'h07);
            end
        end
        check("hold pulses", pulses, 4);
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Random operations with operand noise during RUN
        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            m = model_add(ra, rb, rc);
            run_op(ra, rb, rc, m[W-1:0], m[W], model_ovf(ra, rb, rc),
                   1'b0, 1'b1, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
